// File: rtl/encoder8to3_seq_pkg.sv
// Shared constants, state type and mask helper for the sequential 8-to-3 encoder.
package encoder_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CODE_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    function automatic logic popcnt_is_one(input logic [WIDTH-1:0] mask);
        return (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/encoder8to3_seq_prio_enc8.sv
// Combinational lowest-set-bit finder; the encoding counterpart of Decoder3to8.
module prio_enc8
    import encoder_pkg::*;
(
    input  logic [WIDTH-1:0]  mask,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (mask[i-1]) begin
                idx = CODE_W'(i - 1);
            end
        end
        any = |mask;
    end

endmodule

// File: rtl/encoder8to3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector, then emits the index
// of each set bit, lowest first, one beat per output handshake.
module encoder8to3_seq #(
    parameter int unsigned WIDTH  = encoder_pkg::WIDTH,
    parameter int unsigned CODE_W = encoder_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  Xin,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] Y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              zero
);

    import encoder_pkg::*;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [CODE_W-1:0] idx;
    logic              any;
    logic              final_beat;

    prio_enc8 u_prio (
        .mask (mask_q),
        .idx  (idx),
        .any  (any)
    );

    // An empty mask in EMIT is the single all-zero beat of a zero vector.
    assign final_beat = !any || popcnt_is_one(mask_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d  = Xin;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    mask_d = mask_q & ~(WIDTH'(1) << idx);
                    if (final_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        Y         = (state_q == EMIT) ? idx : '0;
        out_last  = (state_q == EMIT) && final_beat;
        zero      = (state_q == EMIT) && !any;
    end

endmodule

// File: tb/tb_encoder8to3_seq.sv
// Scoreboard bench for encoder8to3_seq: randomized vectors and output stalls
// checked against a bit-list reference model and a decoder reconstruction.
module tb_encoder8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Xin;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] Y;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] y;
        logic       last;
        logic       zero;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] vec_q[$];

    int unsigned ready_mode  = 0;
    int unsigned ready_phase = 0;

    always #5 clk = ~clk;

    encoder8to3_seq #(
        .WIDTH  (8),
        .CODE_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Xin       (Xin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one beat per set bit in ascending order; last beat is
    // the one after which no set bits remain; a zero vector gives one zero-flagged beat.
    function automatic void push_expected(input logic [7:0] v);
        beat_t       b;
        int unsigned remaining;
        vec_q.push_back(v);
        if (v == 8'h00) begin
            b.y    = 3'd0;
            b.last = 1'b1;
            b.zero = 1'b1;
            exp_q.push_back(b);
        end else begin
            remaining = $countones(v);
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    remaining--;
                    b.y    = 3'(i);
                    b.last = (remaining == 0);
                    b.zero = 1'b0;
                    exp_q.push_back(b);
                end
            end
        end
    endfunction

    // Consumer readiness: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1: begin
                    out_ready   = (ready_phase % 3 == 0);
                    ready_phase = ready_phase + 1;
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept (or after EMIT when noisy).
    task automatic send(input logic [7:0] v, input bit noisy);
        int unsigned budget;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (in_ready !== 1'b1) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        Xin      = v;
        in_valid = 1'b1;
        @(posedge clk);
        push_expected(v);
        #1;
        check("first_beat_latency", 32'(out_valid), 32'd1);
        if (noisy) begin
            budget = 0;
            while (out_valid === 1'b1 && budget < 200) begin
                in_valid = 1'b1;
                Xin      = 8'($urandom);
                @(posedge clk);
                #1;
                budget++;
            end
        end
        in_valid = 1'b0;
        Xin      = 8'($urandom);
    endtask

    task automatic drain();
        int unsigned budget;
        budget = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples on the falling edge, between input updates and the next active edge.
    logic       prev_rst     = 1'b1;
    logic       prev_valid   = 1'b0;
    logic       prev_ready   = 1'b0;
    logic       prev_last    = 1'b0;
    logic       prev_zero    = 1'b0;
    logic       prev_in_fire = 1'b0;
    logic [2:0] prev_y       = 3'd0;
    logic [7:0] acc          = 8'h00;
    beat_t      e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                exp_q.delete();
                vec_q.delete();
                acc          = 8'h00;
                prev_rst     = 1'b1;
                prev_valid   = 1'b0;
                prev_in_fire = 1'b0;
                continue;
            end
            if (prev_rst) begin
                check("valid_after_reset", 32'(out_valid), 32'd0);
            end else begin
                check("valid_continuity", 32'(out_valid),
                      32'((prev_valid && !(prev_ready && prev_last)) || prev_in_fire));
            end
            check("in_ready_only_idle", 32'(in_ready), 32'(!out_valid));
            if (!prev_rst && prev_valid && !prev_ready) begin
                check("stall_hold", 32'({out_valid, Y, out_last, zero}),
                      32'({1'b1, prev_y, prev_last, prev_zero}));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got Y=%0d with empty scoreboard, expected no beat at t=%0t",
                             Y, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_y_last_zero", 32'({Y, out_last, zero}), 32'(e));
                    // Decoder3to8 view: each beat of a non-zero vector re-expands to one line.
                    if (!e.zero) begin
                        acc = acc | (8'd1 << Y);
                    end
                    if (e.last) begin
                        if (vec_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL decoder_reconstruct: got 0x%0h with no vector queued, expected none",
                                     acc);
                        end else begin
                            check("decoder_reconstruct", 32'(acc), 32'(vec_q.pop_front()));
                        end
                        acc = 8'h00;
                    end
                end
            end
            prev_rst     = 1'b0;
            prev_valid   = out_valid;
            prev_ready   = out_ready;
            prev_last    = out_last;
            prev_zero    = zero;
            prev_y       = Y;
            prev_in_fire = in_valid && in_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    logic [7:0]  rv;
    int unsigned rsel;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        Xin      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", 32'(Y), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        rst = 1'b0;

        ready_mode = 0;
        send(8'b0000_0100, 1'b0);
        send(8'b1010_0011, 1'b0);
        send(8'h00, 1'b0);
        drain();

        ready_mode  = 1;
        ready_phase = 0;
        send(8'hFF, 1'b0);
        drain();

        // Reset after the first beat of 0x50 discards the remaining bit.
        ready_mode = 0;
        send(8'b0101_0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_emit_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_emit_reset_in_ready", 32'(in_ready), 32'd1);
        send(8'h02, 1'b0);
        drain();

        send(8'b1101_0010, 1'b1);
        drain();

        for (int n = 0; n < 40; n++) begin
            ready_mode = $urandom_range(0, 2);
            rsel       = $urandom_range(0, 9);
            rv         = 8'($urandom);
            if (rsel == 0) rv = 8'h00;
            if (rsel == 1) rv = 8'hFF;
            send(rv, 1'($urandom_range(0, 1)));
        end
        ready_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
